// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
// Module   : div32_seq
// Purpose  : Multi-cycle 32-bit restoring shift-subtract divider. Signed or
//            unsigned operands are accepted through a start/busy/done
//            handshake. One 33-bit trial subtraction per cycle; 32 CALC
//            cycles plus one FIX cycle give a start->done latency of 33.
//            Divide-by-zero completes on the start edge itself.
// Ports    : clk       - clock, rising edge active
//            rst       - synchronous active-high reset
//            start     - request, sampled only while idle
//            signed_op - 1 = two's-complement divide, 0 = unsigned
//            A, B      - dividend / divisor, latched with start
//            Q, R      - quotient / remainder, held until next completion
//            busy      - operation in progress (CALC or FIX)
//            done      - one-cycle completion pulse
//            div_zero  - last operation had B == 0
//            div_ovf   - last operation was signed 0x80000000 / -1
// Revision : 1.0 - initial release
// ============================================================================
module div32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        div_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_dvd;     // dividend magnitude, shifted out MSB first
    logic [31:0] r_dvs;     // divisor magnitude
    logic [31:0] r_rem;     // partial remainder (always < divisor, so 32 bits hold it)
    logic [31:0] r_quo;     // unsigned quotient being assembled
    logic [5:0]  r_cnt;     // iteration counter
    logic        r_neg_q;   // negate quotient in FIX
    logic        r_neg_r;   // negate remainder in FIX
    logic        r_ovf;     // signed 0x80000000 / -1 detected at start

    // Operand magnitudes; 0x80000000 maps onto itself, which is the correct
    // unsigned magnitude.
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    assign w_mag_a = (signed_op && A[31]) ? (~A + 32'd1) : A;
    assign w_mag_b = (signed_op && B[31]) ? (~B + 32'd1) : B;

    // Shift the next dividend bit into the remainder, then trial-subtract.
    // The shifted value needs 33 bits; bit 32 of the difference is the borrow.
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    assign w_rem_sh = {r_rem, r_dvd[31]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_cnt    <= 6'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ovf    <= 1'b0;
            Q        <= 32'd0;
            R        <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (B == 32'd0) begin
                            // Completes immediately; the engine is never entered.
                            Q        <= 32'hFFFF_FFFF;
                            R        <= A;
                            div_zero <= 1'b1;
                            div_ovf  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            r_dvd   <= w_mag_a;
                            r_dvs   <= w_mag_b;
                            r_rem   <= 32'd0;
                            r_quo   <= 32'd0;
                            r_cnt   <= 6'd0;
                            r_neg_q <= signed_op & (A[31] ^ B[31]);
                            r_neg_r <= signed_op & A[31];
                            r_ovf   <= signed_op && (A == 32'h8000_0000) &&
                                       (B == 32'hFFFF_FFFF);
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Overflow needs no special casing: |A|/|B| = 0x80000000 and
                    // the signs agree, so the unnegated quotient is already right.
                    Q        <= r_neg_q ? (~r_quo + 32'd1) : r_quo;
                    R        <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
                    div_zero <= 1'b0;
                    div_ovf  <= r_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_cnt    <= 6'd0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div32_seq
// Purpose  : Directed self-checking bench for div32_seq. Each scenario task
//            drives its own stimulus and compares against hand-computed
//            quotient, remainder, flag and latency values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        div_ovf;

    int checks;
    int errors;

    div32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .A         (A),
        .B         (B),
        .Q         (Q),
        .R         (R),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .div_ovf   (div_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for one edge (E0); returns 1 ns after E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        A = a; B = b; signed_op = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen; -1 when the bound expires.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Q !== 32'd0)      begin errors++; $display("FAIL reset_Q got=%h exp=%h", Q, 32'd0); end
        checks++; if (R !== 32'd0)      begin errors++; $display("FAIL reset_R got=%h exp=%h", R, 32'd0); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        checks++; if (div_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", div_ovf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat;
        start_op(32'd100, 32'd7, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u_busy_after_E0 got=%b exp=1", busy); end
        wait_done(lat);
        checks++; if (lat != 33)          begin errors++; $display("FAIL u_latency got=%0d exp=33", lat); end
        checks++; if (Q !== 32'd14)       begin errors++; $display("FAIL u_Q got=%h exp=%h", Q, 32'd14); end
        checks++; if (R !== 32'd2)        begin errors++; $display("FAIL u_R got=%h exp=%h", R, 32'd2); end
        checks++; if (div_zero !== 1'b0)  begin errors++; $display("FAIL u_dz got=%b exp=0", div_zero); end
        checks++; if (div_ovf !== 1'b0)   begin errors++; $display("FAIL u_ovf got=%b exp=0", div_ovf); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL u_busy_at_done got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL u_done_width got=%b exp=0", done); end
        checks++; if (Q !== 32'd14)       begin errors++; $display("FAIL u_Q_held got=%h exp=%h", Q, 32'd14); end
    endtask

    task automatic test_signed();
        int lat;
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1);       // -7 / 2
        wait_done(lat);
        checks++; if (lat != 33)            begin errors++; $display("FAIL s1_latency got=%0d exp=33", lat); end
        checks++; if (Q !== 32'hFFFF_FFFD)  begin errors++; $display("FAIL s1_Q got=%h exp=fffffffd", Q); end
        checks++; if (R !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL s1_R got=%h exp=ffffffff", R); end
        start_op(32'd7, 32'hFFFF_FFFE, 1'b1);       // 7 / -2
        wait_done(lat);
        checks++; if (Q !== 32'hFFFF_FFFD)  begin errors++; $display("FAIL s2_Q got=%h exp=fffffffd", Q); end
        checks++; if (R !== 32'd1)          begin errors++; $display("FAIL s2_R got=%h exp=00000001", R); end
        checks++; if (div_ovf !== 1'b0)     begin errors++; $display("FAIL s2_ovf got=%b exp=0", div_ovf); end
    endtask

    task automatic test_div_zero();
        for (int s = 0; s < 2; s++) begin
            start_op(32'h1234_5678, 32'd0, s[0]);
            checks++; if (done !== 1'b1)        begin errors++; $display("FAIL dz%0d_done got=%b exp=1", s, done); end
            checks++; if (Q !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL dz%0d_Q got=%h exp=ffffffff", s, Q); end
            checks++; if (R !== 32'h1234_5678)  begin errors++; $display("FAIL dz%0d_R got=%h exp=12345678", s, R); end
            checks++; if (div_zero !== 1'b1)    begin errors++; $display("FAIL dz%0d_flag got=%b exp=1", s, div_zero); end
            checks++; if (div_ovf !== 1'b0)     begin errors++; $display("FAIL dz%0d_ovf got=%b exp=0", s, div_ovf); end
            checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL dz%0d_busy got=%b exp=0", s, busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL dz%0d_after done=%b busy=%b exp=0/0", s, done, busy); end
        end
    endtask

    task automatic test_overflow();
        int lat;
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat);
        checks++; if (Q !== 32'h8000_0000)  begin errors++; $display("FAIL ovf_Q got=%h exp=80000000", Q); end
        checks++; if (R !== 32'd0)          begin errors++; $display("FAIL ovf_R got=%h exp=00000000", R); end
        checks++; if (div_ovf !== 1'b1)     begin errors++; $display("FAIL ovf_flag got=%b exp=1", div_ovf); end
        checks++; if (div_zero !== 1'b0)    begin errors++; $display("FAIL ovf_dz got=%b exp=0", div_zero); end
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat);
        checks++; if (Q !== 32'd0)          begin errors++; $display("FAIL uovf_Q got=%h exp=00000000", Q); end
        checks++; if (R !== 32'h8000_0000)  begin errors++; $display("FAIL uovf_R got=%h exp=80000000", R); end
        checks++; if (div_ovf !== 1'b0)     begin errors++; $display("FAIL uovf_flag got=%b exp=0", div_ovf); end
    endtask

    task automatic test_busy_ignore();
        int n;
        int extra;
        start_op(32'd1000, 32'd10, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            if (n == 5) begin
                A = 32'd7; B = 32'd0; signed_op = 1'b1; start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 33)         begin errors++; $display("FAIL ign_latency got=%0d exp=33", n); end
        checks++; if (Q !== 32'd100)   begin errors++; $display("FAIL ign_Q got=%h exp=%h", Q, 32'd100); end
        checks++; if (R !== 32'd0)     begin errors++; $display("FAIL ign_R got=%h exp=%h", R, 32'd0); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL ign_dz got=%b exp=0", div_zero); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0)      begin errors++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(32'd50, 32'd6, 1'b0);
        wait_done(n);
        checks++; if (Q !== 32'd8 || R !== 32'd2)
            begin errors++; $display("FAIL b2b_first got=%h/%h exp=00000008/00000002", Q, R); end
        // Still inside the done cycle: issue the next request now.
        A = 32'd9; B = 32'd4; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (n == 10) begin
                checks++; if (Q !== 32'd8 || busy !== 1'b1)
                    begin errors++; $display("FAIL b2b_hold Q=%h busy=%b exp=00000008/1", Q, busy); end
            end
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 33)                    begin errors++; $display("FAIL b2b_latency got=%0d exp=33", n); end
        checks++; if (Q !== 32'd2 || R !== 32'd1) begin errors++; $display("FAIL b2b_second got=%h/%h exp=00000002/00000001", Q, R); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int extra;
        start_op(32'h1234_5678, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (Q !== 32'd0 || R !== 32'd0) begin errors++; $display("FAIL rmid_QR got=%h/%h exp=0/0", Q, R); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || div_ovf !== 1'b0)
            begin errors++; $display("FAIL rmid_flags busy=%b done=%b dz=%b ovf=%b exp=0", busy, done, div_zero, div_ovf); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL rmid_done got=%0d exp=0", extra); end
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done(lat);
        checks++; if (lat != 33)           begin errors++; $display("FAIL rmid_latency got=%0d exp=33", lat); end
        checks++; if (Q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rmid_Q got=%h exp=ffffffff", Q); end
        checks++; if (R !== 32'd0)         begin errors++; $display("FAIL rmid_R got=%h exp=00000000", R); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
